cam_capture_gen: RTL and testbench
==================================

# cam_capture_gen

Parametrised DVP camera capture front end in the `cmos_pclk` domain. It gates capture on `cfg_done` and discards a programmable number of start-up frames. It assembles `BEATS` bus beats of `DATA_W` bits into one pixel word and emits a per-pixel strobe with start-of-frame and end-of-line markers. It measures the width and height of each completed frame and flags malformed lines, and it feeds the pixel-to-SDRAM write path.

## Interface
- `DATA_W`, 8: width of the camera data bus.
- `BEATS`, 2: bus beats per pixel word, legal range 1..4.
- `SKIP_FRAMES`, 30: VSYNC rising edges to discard after config; 0 means no skip.
- `CNT_W`, 12: width of the pixel and line counters.
- `cmos_pclk` input 1: camera pixel clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_done` input 1: sensor configuration complete. Asynchronous; double-flopped internally.
- `cmos_vsyn` input 1: VSYNC, high means blanking.
- `cmos_href` input 1: HREF, high means valid beat.
- `cmos_data` input DATA_W: beat data.
- `pix_data` output DATA_W*BEATS: assembled pixel. The first beat sits in the MSBs.
- `pix_en` output 1: one-cycle strobe marking `pix_data` valid.
- `pix_sof` output 1: high with the first `pix_en` of each frame.
- `pix_eol` output 1: one-cycle pulse at the end of each captured line.
- `frame_done` output 1: one-cycle pulse at the end of each frame.
- `frame_width` output CNT_W: pixel count of the last line of the last completed frame.
- `frame_height` output CNT_W: number of lines in the last completed frame.
- `pix_err` output 1: sticky flag for a partial pixel at a line or frame end.

## Operation
- **Input registering.** `vs_d1`/`vs_d2` and `href_d1` are registered copies of the inputs.
  - `vsyn_rise = vs_d1 & ~vs_d2`
  - `vsyn_fall = ~vs_d1 & vs_d2`
  - `href_fall = href_d1 & ~cmos_href`
  - `cfg_sync` is the second flop of `cfg_done`.
- **States:**
  - WAIT_CFG: moves to SKIP when `cfg_sync`=1, with `skip_cnt` cleared. If `SKIP_FRAMES`=0, it moves directly to ARMED.
  - SKIP: each `vsyn_rise` increments `skip_cnt`. The rise that brings it to `SKIP_FRAMES` moves the FSM to ARMED.
  - ARMED: moves to ACTIVE on `vsyn_fall`. Line, pixel and beat counters clear and the SOF flag is set.
  - ACTIVE: captures data. On `vsyn_rise` it pulses `frame_done`, latches `frame_width`/`frame_height`, and returns to ARMED.
- **Config drop.** `cfg_sync`=0 in any state forces WAIT_CFG. It clears `skip_cnt`, all counters and `pix_err`; the width and height registers hold their values.
- **Capture.** Capture occurs only in ACTIVE, with `cmos_href`=1 and `cmos_vsyn`=0.
  - The beat shifts in: `shreg <= {shreg, cmos_data}`, and `beat` increments.
  - When `beat`=BEATS-1, `pix_data` loads the full word, `pix_en`=1, `beat` wraps to 0, and `pix_cnt` increments.
  - `pix_sof` equals the SOF flag on that strobe; the flag then clears.
- **Line end.** On `href_fall` in ACTIVE:
  - `pix_eol`=1, `line_cnt` increments, `last_width<=pix_cnt`, and `pix_cnt` clears.
  - If `beat`≠0, the partial pixel is discarded, `beat` is set to 0 and `pix_err` is set.
  - A line with zero pixels still counts as a line.
- **Frame end.** `vsyn_rise` during a line, with `beat`≠0, discards the partial pixel and sets `pix_err`.
  - The unfinished line is not counted.
  - `frame_width` takes `last_width`; `frame_height` takes `line_cnt`.
- **Counters.** `pix_cnt` and `line_cnt` saturate at 2^CNT_W-1 with no wrap; saturation does not set `pix_err`.
- **Event priority:** `cfg_sync` drop, then `vsyn_rise`, then `href_fall`, then capture.
  - A simultaneous `vsyn_rise` and `href_fall` in ACTIVE gives `pix_eol` and `frame_done` in the same cycle, and the line is counted.

## Timing
- **Reset values:** state WAIT_CFG; all outputs, counters and shift register are 0.
- **Pixel latency.** `pix_en` is asserted by the clock edge that samples the last beat and lasts exactly one cycle. There is at most one `pix_en` per BEATS cycles. With BEATS=1, `pix_en` follows HREF continuously.
- **Line end.** `pix_eol` is asserted by the edge that first samples HREF low.
- **Frame end.** `frame_done` is asserted 2 edges after `cmos_vsyn` is first sampled high; capture stops immediately when raw VSYNC goes high.
- **Config.** `cfg_done` takes effect 2 edges after it changes.
- **Frame start.** The first frame is captured starting at the first `vsyn_fall` after the skip count is reached. A frame that is already in progress when ARMED is entered is ignored.

## Test plan
- **Reset and skip.** Apply reset, set `cfg_done`=1, `SKIP_FRAMES`=3, and drive 5 frames of 4 lines × 6 pixels (BEATS=2). Require: no `pix_en` in frames 1-3, then 24 `pix_en` per frame, `frame_done`×2, and `frame_width`=6, `frame_height`=4.
- **Beat packing.** BEATS=2, beats 0xA5 then 0x3C. Require `pix_data`=0xA53C on the edge of the second beat. The first pixel of the frame has `pix_sof`=1; all later pixels have 0.
- **Partial line.** Drop HREF after 5 beats with BEATS=2. Require 2 `pix_en`, `pix_eol`=1, `pix_err`=1 (sticky), and the next line's pixels correctly aligned.
- **Config drop.** Pull `cfg_done` low mid-line. Within 2 edges require state WAIT_CFG, no further `pix_en`, no `frame_done`, and `pix_err` cleared. Raising it again restarts the full skip count.
- **Parameter sweep.** Run with `DATA_W`=10, BEATS=1 and `SKIP_FRAMES`=0. Require capture from the first frame, one `pix_en` per HREF cycle, and `pix_data` equal to `cmos_data` delayed 1 cycle.
- **Saturation.** Use `CNT_W`=3 with a 10-pixel line. Require `frame_width`=7 and no wrap.

Source files
------------

// File: rtl/cam_capture_gen.sv
// DVP camera capture front end: config gating, start-up frame skip, beat-to-pixel packing,
// and per-frame width/height measurement, all in the cmos_pclk domain.
module cam_capture_gen #(
    parameter int DATA_W      = 8,
    parameter int BEATS       = 2,
    parameter int SKIP_FRAMES = 30,
    parameter int CNT_W       = 12
) (
    input  logic                    cmos_pclk,
    input  logic                    rst_n,
    input  logic                    cfg_done,
    input  logic                    cmos_vsyn,
    input  logic                    cmos_href,
    input  logic [DATA_W-1:0]       cmos_data,
    output logic [DATA_W*BEATS-1:0] pix_data,
    output logic                    pix_en,
    output logic                    pix_sof,
    output logic                    pix_eol,
    output logic                    frame_done,
    output logic [CNT_W-1:0]        frame_width,
    output logic [CNT_W-1:0]        frame_height,
    output logic                    pix_err
);

    // state    | meaning
    // WAIT_CFG | sensor not configured, everything held clear
    // SKIP     | discarding start-up frames, counting VSYNC rises
    // ARMED    | waiting for the start of the next frame (VSYNC fall)
    // ACTIVE   | capturing lines of the current frame

    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {WAIT_CFG, SKIP, ARMED, ACTIVE} state_t;

    state_t              r_state;
    logic                r_vs_d1, r_vs_d2, r_href_d1;
    logic                r_cfg_meta, r_cfg_sync;
    logic [SKIP_W-1:0]   r_skip_cnt;
    logic [BEAT_W-1:0]   r_beat;
    logic [CNT_W-1:0]    r_pix_cnt, r_line_cnt, r_last_width;
    logic                r_sof;

    logic                     w_vsyn_rise, w_vsyn_fall, w_href_fall, w_cap, w_beat_last;
    logic [CNT_W-1:0]         w_pix_inc, w_line_inc;
    logic [DATA_W*BEATS-1:0]  w_word;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1    <= 1'b0;
            r_vs_d2    <= 1'b0;
            r_href_d1  <= 1'b0;
            r_cfg_meta <= 1'b0;
            r_cfg_sync <= 1'b0;
        end else begin
            r_vs_d1    <= cmos_vsyn;
            r_vs_d2    <= r_vs_d1;
            r_href_d1  <= cmos_href;
            r_cfg_meta <= cfg_done;
            r_cfg_sync <= r_cfg_meta;
        end
    end

    assign w_vsyn_rise = r_vs_d1 & ~r_vs_d2;
    assign w_vsyn_fall = ~r_vs_d1 & r_vs_d2;
    assign w_href_fall = r_href_d1 & ~cmos_href;
    assign w_beat_last = (r_beat == BEAT_W'(BEATS - 1));
    assign w_pix_inc   = (r_pix_cnt == CNT_MAX) ? r_pix_cnt : r_pix_cnt + 1'b1;
    assign w_line_inc  = (r_line_cnt == CNT_MAX) ? r_line_cnt : r_line_cnt + 1'b1;

    // Capture loses to every higher-priority event in the same cycle.
    assign w_cap = r_cfg_sync && (r_state == ACTIVE) && !w_vsyn_rise && !w_href_fall
                   && cmos_href && !cmos_vsyn;

    generate
        if (BEATS == 1) begin : g_one_beat
            assign w_word = cmos_data;
        end else begin : g_multi_beat
            logic [DATA_W*(BEATS-1)-1:0] r_shreg;
            always_ff @(posedge cmos_pclk or negedge rst_n) begin
                if (!rst_n)
                    r_shreg <= '0;
                else if (w_cap)
                    r_shreg <= w_word[DATA_W*(BEATS-1)-1:0];
            end
            assign w_word = {r_shreg, cmos_data};
        end
    endgenerate

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= WAIT_CFG;
            r_skip_cnt   <= '0;
            r_beat       <= '0;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_last_width <= '0;
            r_sof        <= 1'b0;
            pix_data     <= '0;
            pix_en       <= 1'b0;
            pix_sof      <= 1'b0;
            pix_eol      <= 1'b0;
            frame_done   <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            pix_err      <= 1'b0;
        end else begin
            pix_en     <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            if (!r_cfg_sync) begin
                // Frame geometry registers deliberately keep their last values.
                r_state      <= WAIT_CFG;
                r_skip_cnt   <= '0;
                r_beat       <= '0;
                r_pix_cnt    <= '0;
                r_line_cnt   <= '0;
                r_last_width <= '0;
                r_sof        <= 1'b0;
                pix_err      <= 1'b0;
            end else begin
                case (r_state)
                    WAIT_CFG: begin
                        r_skip_cnt <= '0;
                        r_state    <= (SKIP_FRAMES == 0) ? ARMED : SKIP;
                    end
                    SKIP: begin
                        if (w_vsyn_rise) begin
                            r_skip_cnt <= r_skip_cnt + 1'b1;
                            if (r_skip_cnt == SKIP_W'(SKIP_FRAMES - 1))
                                r_state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (w_vsyn_fall) begin
                            r_state      <= ACTIVE;
                            r_beat       <= '0;
                            r_pix_cnt    <= '0;
                            r_line_cnt   <= '0;
                            r_last_width <= '0;
                            r_sof        <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (w_vsyn_rise) begin
                            frame_done <= 1'b1;
                            r_state    <= ARMED;
                            r_beat     <= '0;
                            if (r_beat != '0)
                                pix_err <= 1'b1;
                            // A line ending on the same edge still counts.
                            if (w_href_fall) begin
                                pix_eol      <= 1'b1;
                                frame_width  <= r_pix_cnt;
                                frame_height <= w_line_inc;
                            end else begin
                                frame_width  <= r_last_width;
                                frame_height <= r_line_cnt;
                            end
                        end else if (w_href_fall) begin
                            pix_eol      <= 1'b1;
                            r_line_cnt   <= w_line_inc;
                            r_last_width <= r_pix_cnt;
                            r_pix_cnt    <= '0;
                            r_beat       <= '0;
                            if (r_beat != '0)
                                pix_err <= 1'b1;
                        end else if (w_cap) begin
                            if (w_beat_last) begin
                                pix_data  <= w_word;
                                pix_en    <= 1'b1;
                                pix_sof   <= r_sof;
                                r_sof     <= 1'b0;
                                r_beat    <= '0;
                                r_pix_cnt <= w_pix_inc;
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end
                    end
                    default: r_state <= WAIT_CFG;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_gen.sv
// Directed bench: instance A (8-bit, 2 beats, skip 3) covers skip, packing, partial lines and
// config drop; instance B (10-bit, 1 beat, no skip, 3-bit counters) covers pass-through and saturation.
module tb_cam_capture_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_a, cfg_b;
    logic        vs, href;
    logic [7:0]  d_a;
    logic [9:0]  d_b;

    logic [15:0] pix_data_a;
    logic        pix_en_a, pix_sof_a, pix_eol_a, frame_done_a, pix_err_a;
    logic [11:0] frame_width_a, frame_height_a;

    logic [9:0]  pix_data_b;
    logic        pix_en_b, pix_sof_b, pix_eol_b, frame_done_b, pix_err_b;
    logic [2:0]  frame_width_b, frame_height_b;

    int n_asrt = 0;
    int n_fail = 0;
    int n_en = 0, n_sof = 0, n_fd = 0, n_eol = 0, n_en_b = 0, n_fd_b = 0;
    logic [15:0] last_pix = '0;
    logic [15:0] sof_pix  = '0;
    int e0, e1;

    cam_capture_gen #(.DATA_W(8), .BEATS(2), .SKIP_FRAMES(3), .CNT_W(12)) dut_a (
        .cmos_pclk(clk), .rst_n(rst_n), .cfg_done(cfg_a), .cmos_vsyn(vs), .cmos_href(href),
        .cmos_data(d_a), .pix_data(pix_data_a), .pix_en(pix_en_a), .pix_sof(pix_sof_a),
        .pix_eol(pix_eol_a), .frame_done(frame_done_a), .frame_width(frame_width_a),
        .frame_height(frame_height_a), .pix_err(pix_err_a)
    );

    cam_capture_gen #(.DATA_W(10), .BEATS(1), .SKIP_FRAMES(0), .CNT_W(3)) dut_b (
        .cmos_pclk(clk), .rst_n(rst_n), .cfg_done(cfg_b), .cmos_vsyn(vs), .cmos_href(href),
        .cmos_data(d_b), .pix_data(pix_data_b), .pix_en(pix_en_b), .pix_sof(pix_sof_b),
        .pix_eol(pix_eol_b), .frame_done(frame_done_b), .frame_width(frame_width_b),
        .frame_height(frame_height_b), .pix_err(pix_err_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_en_a) begin
            n_en     <= n_en + 1;
            last_pix <= pix_data_a;
            if (pix_sof_a) begin
                n_sof   <= n_sof + 1;
                sof_pix <= pix_data_a;
            end
        end
        if (frame_done_a) n_fd   <= n_fd + 1;
        if (pix_eol_a)    n_eol  <= n_eol + 1;
        if (pix_en_b)     n_en_b <= n_en_b + 1;
        if (frame_done_b) n_fd_b <= n_fd_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel j of a line: j=0 is A5,3C; otherwise (10+j),(20+j).
    function automatic logic [7:0] pat(input int k);
        int j;
        j = k / 2;
        if (j == 0) return (k % 2 == 0) ? 8'hA5 : 8'h3C;
        return (k % 2 == 0) ? 8'(8'h10 + j) : 8'(8'h20 + j);
    endfunction

    task automatic cyc(input logic v, input logic h, input logic [7:0] da, input logic [9:0] db);
        vs = v; href = h; d_a = da; d_b = db;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 10'h000);
    endtask

    task automatic send_line(input int nb);
        for (int k = 0; k < nb; k++) cyc(1'b0, 1'b1, pat(k), 10'h000);
        cyc(1'b0, 1'b0, 8'h00, 10'h000);
    endtask

    task automatic vs_pulse();
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 10'h000);
        idle(4);
    endtask

    task automatic frame_a();
        repeat (4) begin
            send_line(12);
            idle(2);
        end
        vs_pulse();
    endtask

    initial begin
        rst_n = 1'b0; cfg_a = 1'b0; cfg_b = 1'b0;
        vs = 1'b0; href = 1'b0; d_a = '0; d_b = '0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        chk("rst_pix_en",   pix_en_a,       0);
        chk("rst_pix_data", pix_data_a,     0);
        chk("rst_pix_sof",  pix_sof_a,      0);
        chk("rst_pix_eol",  pix_eol_a,      0);
        chk("rst_fdone",    frame_done_a,   0);
        chk("rst_width",    frame_width_a,  0);
        chk("rst_height",   frame_height_a, 0);
        chk("rst_err",      pix_err_a,      0);
        chk("rst_b_data",   pix_data_b,     0);

        // Skip three frames, capture the next two.
        cfg_a = 1'b1;
        idle(4);
        repeat (3) frame_a();
        chk("skip_no_en",    n_en, 0);
        chk("skip_no_fdone", n_fd, 0);
        frame_a();
        chk("f4_en_count", n_en,           24);
        chk("f4_fdone",    n_fd,           1);
        chk("f4_eol",      n_eol,          4);
        chk("f4_sof_cnt",  n_sof,          1);
        chk("f4_sof_pix",  sof_pix,        16'hA53C);
        chk("f4_last_pix", last_pix,       16'h1525);
        chk("f4_width",    frame_width_a,  6);
        chk("f4_height",   frame_height_a, 4);
        chk("f4_err",      pix_err_a,      0);
        frame_a();
        chk("f5_en_count", n_en,           48);
        chk("f5_fdone",    n_fd,           2);
        chk("f5_sof_cnt",  n_sof,          2);
        chk("f5_width",    frame_width_a,  6);
        chk("f5_height",   frame_height_a, 4);

        // Partial line: 5 beats -> 2 pixels, trailing beat discarded.
        e0 = n_en;
        send_line(5);
        chk("part_eol",      pix_eol_a,  1);
        chk("part_err",      pix_err_a,  1);
        chk("part_en",       n_en - e0,  2);
        chk("part_last_pix", last_pix,   16'h1121);
        idle(2);
        send_line(12);
        chk("realign_en",    n_en - e0,  8);
        chk("realign_pix",   last_pix,   16'h1525);
        chk("err_sticky",    pix_err_a,  1);
        idle(2);

        // Config drop mid-line.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, pat(k), 10'h000);
        cfg_a = 1'b0;
        for (int k = 3; k < 6; k++) cyc(1'b0, 1'b1, pat(k), 10'h000);
        e1 = n_en;
        chk("drop_err_clr", pix_err_a, 0);
        for (int k = 6; k < 11; k++) cyc(1'b0, 1'b1, pat(k), 10'h000);
        cyc(1'b0, 1'b0, 8'h00, 10'h000);
        chk("drop_no_eol",  pix_eol_a, 0);
        vs_pulse();
        chk("drop_no_en",     n_en,           e1);
        chk("drop_no_fdone",  n_fd,           2);
        chk("drop_width_hld", frame_width_a,  6);
        chk("drop_hgt_hld",   frame_height_a, 4);

        // Re-enable: full skip count applies again.
        cfg_a = 1'b1;
        idle(4);
        repeat (3) frame_a();
        chk("reskip_no_en", n_en, e1);
        chk("reskip_fdone", n_fd, 2);
        frame_a();
        chk("recap_en",     n_en, e1 + 24);
        chk("recap_fdone",  n_fd, 3);
        chk("recap_width",  frame_width_a, 6);

        // Instance B: one beat per pixel, no skip, 3-bit counters.
        cfg_b = 1'b1;
        idle(4);
        vs_pulse();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 8'h00, 10'(10'h3A0 + k));
            if (k == 0) begin
                chk("b_first_en",  pix_en_b,   1);
                chk("b_first_sof", pix_sof_b,  1);
                chk("b_first_pix", pix_data_b, 10'h3A0);
            end
        end
        cyc(1'b0, 1'b0, 8'h00, 10'h000);
        chk("b_eol1", pix_eol_b, 1);
        idle(2);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 8'h00, 10'(10'h2C0 + 3 * k));
            chk("b_pix_en",   pix_en_b,   1);
            chk("b_pix_data", pix_data_b, 10'(10'h2C0 + 3 * k));
            if (k == 0) chk("b_no_sof", pix_sof_b, 0);
        end
        cyc(1'b0, 1'b0, 8'h00, 10'h000);
        chk("b_eol2",    pix_eol_b, 1);
        chk("b_en_gap",  pix_en_b,  0);
        idle(2);
        vs_pulse();
        chk("b_en_count", n_en_b,         13);
        chk("b_fdone",    n_fd_b,         1);
        chk("b_sat_width", frame_width_b, 7);
        chk("b_height",   frame_height_b, 2);
        chk("b_err",      pix_err_b,      0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
